banked_register_file: RTL

Parametrised successor to the core's flat register file. Provides ARM-style mode-banked general registers (R0–R14 plus a read-only R15/PC view), configurable read-port count and data width, and two write ports (ALU/load result and base-register writeback). Storage is cleared by a post-reset init sequencer rather than a wide asynchronous reset. Sits between ID (reads) and WB (writes) in the 5-stage pipeline.

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_map.sv | 36 +++
 rtl/banked_register_file.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the mode-banked register file.
// Physical map: USR R0-R14 at 0-14, FIQ R8-R14 at 15-21, IRQ R13-R14 at 22-23, SVC R13-R14 at 24-25.
package regfile_pkg;

    typedef enum logic [1:0] {
        MODE_USR = 2'b00,
        MODE_FIQ = 2'b01,
        MODE_IRQ = 2'b10,
        MODE_SVC = 2'b11
    } mode_e;

    typedef enum logic {
        StInit,
        StRun
    } seq_state_e;

    localparam int unsigned PHYS_N   = 26;
    localparam int unsigned PHYS_W   = 5;
    localparam int unsigned FIQ_BASE = 15;
    localparam int unsigned IRQ_BASE = 22;
    localparam int unsigned SVC_BASE = 24;
    localparam logic [3:0]  PC_IDX   = 4'd15;

    // Physical slot of a banked register: bank base plus offset from the first banked index.
    function automatic logic [PHYS_W-1:0] bank_entry(input int unsigned base,
                                                     input int unsigned idx,
                                                     input int unsigned first);
        return PHYS_W'(base + idx - first);
    endfunction

endpackage

// File: rtl/regfile_map.sv
// Logical register index plus processor mode to physical storage slot.
// Pure combinational; one instance per read port and per write port.
module regfile_map
    import regfile_pkg::*;
(
    input  mode_e                   mode,
    input  logic [3:0]              idx,
    output logic [PHYS_W-1:0]       phys,
    output logic                    is_pc
);

    always_comb begin
        is_pc = (idx == PC_IDX);
        phys  = {1'b0, idx};
        unique case (mode)
            MODE_FIQ: begin
                if (idx >= 4'd8 && !is_pc) begin
                    phys = bank_entry(FIQ_BASE, 32'(idx), 8);
                end
            end
            MODE_IRQ: begin
                if (idx == 4'd13 || idx == 4'd14) begin
                    phys = bank_entry(IRQ_BASE, 32'(idx), 13);
                end
            end
            MODE_SVC: begin
                if (idx == 4'd13 || idx == 4'd14) begin
                    phys = bank_entry(SVC_BASE, 32'(idx), 13);
                end
            end
            MODE_USR: begin
            end
        endcase
    end

endmodule

// File: rtl/banked_register_file.sv
// ARM-style mode-banked register file with NUM_RD read ports, two write ports and an init sequencer.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module banked_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_RD = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 rd_mode,
    input  logic [NUM_RD*4-1:0]        rd_idx,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic                       wb0_en,
    input  logic [3:0]                 wb0_idx,
    input  logic [DATA_W-1:0]          wb0_data,
    input  logic                       wb1_en,
    input  logic [3:0]                 wb1_idx,
    input  logic [DATA_W-1:0]          wb1_data,
    input  logic [1:0]                 wb_mode,
    output logic                       ready
);

    seq_state_e              state;
    logic [PHYS_W-1:0]       init_cnt;
    logic [DATA_W-1:0]       mem [0:PHYS_N-1];

    mode_e                   rd_mode_e;
    mode_e                   wb_mode_e;
    logic [PHYS_W-1:0]       wb0_phys;
    logic [PHYS_W-1:0]       wb1_phys;
    logic                    wb0_is_pc;
    logic                    wb1_is_pc;
    logic                    wr0;
    logic                    wr1;

    assign rd_mode_e = mode_e'(rd_mode);
    assign wb_mode_e = mode_e'(wb_mode);

    regfile_map u_map_wb0 (
        .mode  (wb_mode_e),
        .idx   (wb0_idx),
        .phys  (wb0_phys),
        .is_pc (wb0_is_pc)
    );

    regfile_map u_map_wb1 (
        .mode  (wb_mode_e),
        .idx   (wb1_idx),
        .phys  (wb1_phys),
        .is_pc (wb1_is_pc)
    );

    // wb1 yields to wb0 when both resolve to the same physical slot.
    assign wr0 = ready && wb0_en && !wb0_is_pc;
    assign wr1 = ready && wb1_en && !wb1_is_pc && !(wr0 && (wb0_phys == wb1_phys));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StInit;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    if (init_cnt == PHYS_W'(PHYS_N - 1)) begin
                        state <= StRun;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                StRun: begin
                end
                default: state <= StInit;
            endcase
        end
    end

    // Storage has no reset; the sequencer clears one slot per cycle instead.
    always_ff @(posedge clk) begin
        if (state == StInit) begin
            mem[init_cnt] <= '0;
        end else begin
            if (wr0) begin
                mem[wb0_phys] <= wb0_data;
            end
            if (wr1) begin
                mem[wb1_phys] <= wb1_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [PHYS_W-1:0] phys;
        logic              is_pc;
        logic [DATA_W-1:0] val;

        regfile_map u_map_rd (
            .mode  (rd_mode_e),
            .idx   (rd_idx[4*k +: 4]),
            .phys  (phys),
            .is_pc (is_pc)
        );

        always_comb begin
            val = '0;
            if (ready) begin
                if (is_pc) begin
                    val = pc_in;
                end else begin
                    val = mem[phys];
`ifdef REGFILE_BYPASS_EN
                    if (wr0 && (wb0_phys == phys)) begin
                        val = wb0_data;
                    end else if (wr1 && (wb1_phys == phys)) begin
                        val = wb1_data;
                    end
`endif
                end
            end
        end

        assign rd_data[DATA_W*k +: DATA_W] = val;
    end

endmodule
